// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_unit
// Description : Hazard unit for a 5-stage pipeline, sitting beside ID/EX.
//               - Selects the forwarding source for each of the NUM_SRC EX-stage
//                 operands (combinational).
//               - Raises a load-use stall of LOAD_LAT bubbles.
//               - Tracks one multi-cycle (MUL/DIV) unit of MUL_LAT cycles and
//                 stalls ID while it still owes a result that ID needs.
// Ports       :
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   id_src       source registers of the ID instruction (NUM_SRC x REG_AW)
//   id_src_use   per-operand "actually read" flags of the ID instruction
//   id_is_mul    ID instruction is itself a multi-cycle op
//   idex_src     source registers of the EX instruction
//   idex_wr/rd   EX destination write enable / address
//   idex_memrd   EX instruction is a load
//   idex_mul     EX instruction issues to the multi-cycle unit this cycle
//   exmem_wr/rd  MEM destination write enable / address
//   exmem_memrd  MEM instruction is a load (value not yet forwardable)
//   memwb_wr/rd  WB destination write enable / address
//   fwd_sel      per operand: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   stall        hold PC and IF/ID
//   flush_idex   insert bubble into ID/EX (same as stall)
//   mul_busy     multi-cycle unit occupied
//   mul_done     one-cycle pulse when the pending multi-cycle result lands
//   proto_err    sticky: a multi-cycle issue was seen while the unit was busy
// Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1,
    parameter int MUL_LAT  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_use,
    input  logic                      id_is_mul,
    input  logic [NUM_SRC*REG_AW-1:0] idex_src,
    input  logic                      idex_wr,
    input  logic [REG_AW-1:0]         idex_rd,
    input  logic                      idex_memrd,
    input  logic                      idex_mul,
    input  logic                      exmem_wr,
    input  logic [REG_AW-1:0]         exmem_rd,
    input  logic                      exmem_memrd,
    input  logic                      memwb_wr,
    input  logic [REG_AW-1:0]         memwb_rd,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      stall,
    output logic                      flush_idex,
    output logic                      mul_busy,
    output logic                      mul_done,
    output logic                      proto_err
);

    // Counter widths are sized to hold LAT-1 and never collapse to zero bits.
    localparam int c_LCW = $clog2(LOAD_LAT + 1);
    localparam int c_MCW = $clog2(MUL_LAT + 1);

    localparam logic [c_LCW-1:0] c_LOAD_RELOAD = c_LCW'(LOAD_LAT - 1);
    localparam logic [c_MCW-1:0] c_MUL_RELOAD  = c_MCW'(MUL_LAT - 1);
    localparam logic [c_LCW-1:0] c_LOAD_ONE    = c_LCW'(1);
    localparam logic [c_MCW-1:0] c_MUL_ONE     = c_MCW'(1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_BUSY = 1'b1;

    logic [0:0]            r_state;
    logic [c_LCW-1:0]      r_load_cnt;
    logic [c_MCW-1:0]      r_mul_cnt;
    logic [REG_AW-1:0]     r_mul_rd;
    logic                  r_mul_done;
    logic                  r_proto_err;

    logic [2*NUM_SRC-1:0]  w_fwd;
    logic [NUM_SRC-1:0]    w_load_op;
    logic [NUM_SRC-1:0]    w_mul_op;
    logic                  w_load_hit;
    logic                  w_busy;
    logic                  w_mul_hit;
    logic                  w_stall;

    // ------------------------------------------------------------------
    // Per-operand comparators: forwarding for EX operands, dependency
    // checks of the ID operands against the load and multi-cycle targets.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_AW-1:0] w_ex_src;
            logic [REG_AW-1:0] w_id_src;
            logic              w_ex_match;
            logic              w_wb_match;

            assign w_ex_src = idex_src[gi*REG_AW +: REG_AW];
            assign w_id_src = id_src[gi*REG_AW +: REG_AW];

            // A load still in MEM has no data yet, so it must not win the
            // EX/MEM slot; an older WB writer of the same register may.
            assign w_ex_match = (w_ex_src != '0) && exmem_wr && !exmem_memrd
                                && (exmem_rd == w_ex_src);
            assign w_wb_match = (w_ex_src != '0) && memwb_wr
                                && (memwb_rd == w_ex_src);

            assign w_fwd[2*gi +: 2] = w_ex_match ? 2'b10 :
                                      w_wb_match ? 2'b01 : 2'b00;

            assign w_load_op[gi] = id_src_use[gi] && (w_id_src == idex_rd);
            assign w_mul_op[gi]  = id_src_use[gi] && (w_id_src == r_mul_rd);
        end
    endgenerate

    assign w_load_hit = idex_wr && idex_memrd && (idex_rd != '0) && (|w_load_op);
    assign w_busy     = (r_state == c_BUSY);
    // A second multi-cycle op in ID must also wait: the unit holds only one.
    assign w_mul_hit  = w_busy && (((r_mul_rd != '0) && (|w_mul_op)) || id_is_mul);
    assign w_stall    = w_load_hit || (r_load_cnt != '0) || w_mul_hit;

    // Combinational outputs are forced quiet while reset is held low.
    assign fwd_sel    = reset ? w_fwd : '0;
    assign stall      = reset && w_stall;
    assign flush_idex = stall;
    assign mul_busy   = reset && w_busy;
    assign mul_done   = r_mul_done;
    assign proto_err  = r_proto_err;

    // ------------------------------------------------------------------
    // Load-use bubble counter: the hit cycle itself stalls, the counter
    // supplies the remaining LOAD_LAT-1 bubbles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_load_cnt <= '0;
        end else if (w_load_hit) begin
            r_load_cnt <= c_LOAD_RELOAD;
        end else if (r_load_cnt != '0) begin
            r_load_cnt <= r_load_cnt - c_LOAD_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Multi-cycle scoreboard. An issue with no real destination still
    // occupies the unit but records r0, so it never creates a dependency.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_mul_cnt   <= '0;
            r_mul_rd    <= '0;
            r_mul_done  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_mul_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (idex_mul) begin
                        r_state   <= c_BUSY;
                        r_mul_cnt <= c_MUL_RELOAD;
                        r_mul_rd  <= (idex_wr && (idex_rd != '0)) ? idex_rd : '0;
                    end
                end
                c_BUSY: begin
                    // The unit cannot accept a new op; flag it, keep timing.
                    if (idex_mul) begin
                        r_proto_err <= 1'b1;
                    end
                    if (r_mul_cnt == c_MUL_ONE) begin
                        r_state    <= c_IDLE;
                        r_mul_cnt  <= '0;
                        r_mul_done <= 1'b1;
                    end else begin
                        r_mul_cnt <= r_mul_cnt - c_MUL_ONE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
